// File: rtl/acc_alu_seq_if.sv
// Handshake bundle between the operand sequencer, acc_alu_seq and the result sink.
interface acc_alu_seq_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       opcode;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             acc_clr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] ALU_Out;
   logic             flag_z;
   logic             flag_c;
   logic             flag_dz;

   modport master (
      output in_valid, opcode, A, B, acc_clr, out_ready,
      input  in_ready, out_valid, ALU_Out, flag_z, flag_c, flag_dz
   );

   modport slave (
      input  in_valid, opcode, A, B, acc_clr, out_ready,
      output in_ready, out_valid, ALU_Out, flag_z, flag_c, flag_dz
   );
endinterface

// File: rtl/acc_alu_seq.sv
// Accumulator ALU (16-op VS-ALU set) with valid/ready handshakes and a restoring divider.
// Build option: define ALU_SAT_EN to clamp overflowing arithmetic instead of wrapping.
//
// state  | meaning
// S_IDLE | ready for ops; single-cycle results are registered from here
// S_DIV  | restoring division running, one quotient bit per cycle
module acc_alu_seq #(
   parameter int WIDTH = 8
) (
   input logic          clk,
   input logic          rst_n,
   acc_alu_seq_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONES = '1;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd3;
   localparam logic [3:0] OP_ADDA = 4'd4;
   localparam logic [3:0] OP_MULA = 4'd5;
   localparam logic [3:0] OP_MAC  = 4'd6;
   localparam logic [3:0] OP_ROL  = 4'd7;
   localparam logic [3:0] OP_ROR  = 4'd8;
   localparam logic [3:0] OP_AND  = 4'd9;
   localparam logic [3:0] OP_OR   = 4'd10;
   localparam logic [3:0] OP_XOR  = 4'd11;
   localparam logic [3:0] OP_NAND = 4'd12;
   localparam logic [3:0] OP_ETH  = 4'd13;
   localparam logic [3:0] OP_GTH  = 4'd14;
   localparam logic [3:0] OP_LTH  = 4'd15;

   typedef enum logic {S_IDLE, S_DIV} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               out_valid_q, out_valid_d;
   logic               z_q, z_d;
   logic               c_q, c_d;
   logic               dz_q, dz_d;

   logic               in_ready;
   logic               accept;
   logic               clr_en;
   logic [WIDTH-1:0]   acc_eff;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic               alu_dz;
   logic [WIDTH:0]     sum_ab, diff_ab, sum_acc;
   logic [2*WIDTH-1:0] prod_ab, prod_acc;
   logic [2*WIDTH:0]   mac_full;
   logic [WIDTH:0]     rem_sh, trial;
   logic [WIDTH-1:0]   quo_next, rem_next;

   assign in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
   assign accept   = bus.in_valid && in_ready;
   // A clear in the accept cycle applies before the op reads the accumulator.
   assign clr_en   = bus.acc_clr && in_ready;
   assign acc_eff  = clr_en ? '0 : acc_q;

   always_comb begin
      sum_ab   = {1'b0, bus.A} + {1'b0, bus.B};
      diff_ab  = {1'b0, bus.A} - {1'b0, bus.B};
      sum_acc  = {1'b0, acc_eff} + {1'b0, bus.A};
      prod_ab  = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
      prod_acc = {{WIDTH{1'b0}}, acc_eff} * {{WIDTH{1'b0}}, bus.A};
      mac_full = {{(WIDTH+1){1'b0}}, acc_eff} + {1'b0, prod_ab};
   end

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_dz  = 1'b0;
      case (bus.opcode)
         OP_ADD:  begin alu_res = sum_ab[WIDTH-1:0];    alu_c = sum_ab[WIDTH];              end
         OP_SUB:  begin alu_res = diff_ab[WIDTH-1:0];   alu_c = diff_ab[WIDTH];             end
         OP_MUL:  begin alu_res = prod_ab[WIDTH-1:0];   alu_c = |prod_ab[2*WIDTH-1:WIDTH];  end
         // Only the divide-by-zero case resolves here; B!=0 goes to the divider.
         OP_DIV:  begin alu_res = ONES;                 alu_dz = 1'b1;                      end
         OP_ADDA: begin alu_res = sum_acc[WIDTH-1:0];   alu_c = sum_acc[WIDTH];             end
         OP_MULA: begin alu_res = prod_acc[WIDTH-1:0];  alu_c = |prod_acc[2*WIDTH-1:WIDTH]; end
         OP_MAC:  begin alu_res = mac_full[WIDTH-1:0];  alu_c = |mac_full[2*WIDTH:WIDTH];   end
         OP_ROL:  alu_res = {bus.A[WIDTH-2:0], bus.A[WIDTH-1]};
         OP_ROR:  alu_res = {bus.A[0], bus.A[WIDTH-1:1]};
         OP_AND:  alu_res = bus.A & bus.B;
         OP_OR:   alu_res = bus.A | bus.B;
         OP_XOR:  alu_res = bus.A ^ bus.B;
         OP_NAND: alu_res = ~(bus.A & bus.B);
         OP_ETH:  alu_res = (bus.A == bus.B) ? ONES : '0;
         OP_GTH:  alu_res = (bus.A > bus.B)  ? ONES : '0;
         OP_LTH:  alu_res = (bus.A < bus.B)  ? ONES : '0;
         default: alu_res = '0;
      endcase
`ifdef ALU_SAT_EN
      if (alu_c) begin
         alu_res = (bus.opcode == OP_SUB) ? '0 : ONES;
      end
`endif
   end

   // One restoring-division step: shift in the next dividend bit, trial-subtract.
   always_comb begin
      rem_sh = {rem_q, quo_q[WIDTH-1]};
      trial  = rem_sh - {1'b0, dvs_q};
      if (trial[WIDTH]) begin
         rem_next = rem_sh[WIDTH-1:0];
         quo_next = {quo_q[WIDTH-2:0], 1'b0};
      end else begin
         rem_next = trial[WIDTH-1:0];
         quo_next = {quo_q[WIDTH-2:0], 1'b1};
      end
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      res_d       = res_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      rem_d       = rem_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      z_d         = z_q;
      c_d         = c_q;
      dz_d        = dz_q;
      case (state_q)
         S_IDLE: begin
            if (out_valid_q && bus.out_ready) begin
               out_valid_d = 1'b0;
            end
            if (clr_en) begin
               acc_d = '0;
            end
            if (accept) begin
               if ((bus.opcode == OP_DIV) && (bus.B != '0)) begin
                  state_d = S_DIV;
                  quo_d   = bus.A;
                  dvs_d   = bus.B;
                  rem_d   = '0;
                  cnt_d   = DIV_CNT_INIT;
               end else begin
                  res_d       = alu_res;
                  acc_d       = alu_res;
                  z_d         = (alu_res == '0);
                  c_d         = alu_c;
                  dz_d        = alu_dz;
                  out_valid_d = 1'b1;
               end
            end
         end
         S_DIV: begin
            quo_d = quo_next;
            rem_d = rem_next;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
               state_d     = S_IDLE;
               res_d       = quo_next;
               acc_d       = quo_next;
               z_d         = (quo_next == '0);
               c_d         = 1'b0;
               dz_d        = 1'b0;
               out_valid_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         res_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         z_q         <= 1'b0;
         c_q         <= 1'b0;
         dz_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         res_q       <= res_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         rem_q       <= rem_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         z_q         <= z_d;
         c_q         <= c_d;
         dz_q        <= dz_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.ALU_Out   = res_q;
   assign bus.flag_z    = z_q;
   assign bus.flag_c    = c_q;
   assign bus.flag_dz   = dz_q;
endmodule

// File: tb/tb_acc_alu_seq.sv
// Self-checking bench for acc_alu_seq: directed vector table, stall/reset sequences, random ops vs model.
`timescale 1ns/1ps
module tb_acc_alu_seq;
   localparam int W    = 8;
   localparam int MOD  = 1 << W;
   localparam int MAXV = MOD - 1;
`ifdef ALU_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;
   int   acc_m = 0;

   acc_alu_seq_if #(.WIDTH(W)) bus ();
   acc_alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   always #5 clk = ~clk;

   typedef struct {
      int op; int a; int b; bit clr;
      int res; bit c; bit dz;
   } vec_t;
   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the full-precision result.
   function automatic void ref_alu(input int op, input int a, input int b, input int av,
                                   output int res, output bit c, output bit dz);
      int full;
      case (op)
         0:  full = a + b;
         1:  full = a - b;
         2:  full = a * b;
         3:  full = (b == 0) ? MAXV : a / b;
         4:  full = av + a;
         5:  full = av * a;
         6:  full = av + a * b;
         7:  full = (a * 2) % MOD + a / (MOD / 2);
         8:  full = a / 2 + (a % 2) * (MOD / 2);
         9:  full = a & b;
         10: full = a | b;
         11: full = a ^ b;
         12: full = MAXV - (a & b);
         13: full = (a == b) ? MAXV : 0;
         14: full = (a > b) ? MAXV : 0;
         default: full = (a < b) ? MAXV : 0;
      endcase
      dz  = (op == 3) && (b == 0);
      c   = (op inside {0, 1, 2, 4, 5, 6}) && (full < 0 || full > MAXV);
      res = ((full % MOD) + MOD) % MOD;
      if (SAT && c) res = (op == 1) ? 0 : MAXV;
   endfunction

   task automatic run_op(input int op, input int a, input int b, input bit clr,
                         input int e_res, input bit e_c, input bit e_dz, input string name);
      int lat, busy, waited, e_lat;
      e_lat = (op == 3 && b != 0) ? W + 1 : 1;
      @(negedge clk);
      bus.in_valid = 1'b1; bus.opcode = 4'(op); bus.A = W'(a); bus.B = W'(b);
      bus.acc_clr = clr; bus.out_ready = 1'b1;
      #1;
      waited = 0;
      while (!bus.in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) chk({name, "_accept"}, int'(bus.in_ready), 1);
      @(negedge clk);
      bus.in_valid = 1'b0; bus.acc_clr = 1'b0;
      lat = 1; busy = 0;
      while (!bus.out_valid && lat < 40) begin
         if (!bus.in_ready) busy++;
         @(negedge clk);
         lat++;
      end
      chk({name, "_latency"}, lat, e_lat);
      chk({name, "_busy"}, busy, e_lat - 1);
      chk({name, "_result"}, int'(bus.ALU_Out), e_res);
      chk({name, "_flag_c"}, int'(bus.flag_c), int'(e_c));
      chk({name, "_flag_dz"}, int'(bus.flag_dz), int'(e_dz));
      chk({name, "_flag_z"}, int'(bus.flag_z), int'(e_res == 0));
      acc_m = e_res;
   endtask

   task automatic model_op(input int op, input int a, input int b, input bit clr, input string name);
      int r; bit c, dz;
      ref_alu(op, a, b, clr ? 0 : acc_m, r, c, dz);
      run_op(op, a, b, clr, r, c, dz, name);
   endtask

   function automatic void addv(input int op, input int a, input int b, input bit clr,
                                input int res, input bit c, input bit dz);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.clr = clr; v.res = res; v.c = c; v.dz = dz;
      vecs.push_back(v);
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      addv(0,  200, 100, 0, SAT ? 255 : 44,  1, 0);
      addv(1,  5,   7,   0, SAT ? 0 : 254,   1, 0);
      addv(1,  7,   5,   0, 2,               0, 0);
      addv(3,  200, 7,   0, 28,              0, 0);
      addv(3,  9,   0,   0, 255,             0, 1);
      addv(2,  16,  16,  0, SAT ? 255 : 0,   1, 0);
      addv(6,  3,   4,   1, 12,              0, 0);
      addv(6,  5,   6,   0, 42,              0, 0);
      addv(4,  250, 0,   0, SAT ? 255 : 36,  1, 0);
      addv(5,  0,   0,   0, 0,               0, 0);
      addv(7,  129, 0,   0, 3,               0, 0);
      addv(8,  129, 0,   0, 192,             0, 0);
      addv(12, 240, 255, 0, 15,              0, 0);
      addv(14, 5,   3,   0, 255,             0, 0);
      addv(15, 5,   3,   0, 0,               0, 0);
      addv(13, 7,   7,   0, 255,             0, 0);
      addv(9,  204, 170, 0, 136,             0, 0);
      addv(10, 204, 170, 0, 238,             0, 0);
      addv(11, 204, 170, 0, 102,             0, 0);
      addv(3,  7,   200, 0, 0,               0, 0);
      addv(3,  255, 1,   0, 255,             0, 0);

      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.opcode = '0; bus.A = '0; bus.B = '0;
      bus.acc_clr = 1'b0; bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_out_valid", int'(bus.out_valid), 0);
      chk("reset_alu_out", int'(bus.ALU_Out), 0);
      chk("reset_flags", int'({bus.flag_z, bus.flag_c, bus.flag_dz}), 0);
      rst_n = 1'b1;
      #1;
      chk("reset_in_ready", int'(bus.in_ready), 1);

      for (int i = 0; i < vecs.size(); i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].clr,
                vecs[i].res, vecs[i].c, vecs[i].dz, $sformatf("vec%0d_op%0d", i, vecs[i].op));
      end

      // Backpressure: result held, new op ignored, then back-to-back on release.
      model_op(0, 1, 2, 1'b1, "bp_setup");
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.opcode = 4'd0; bus.A = 8'd1; bus.B = 8'd2;
      #1;
      chk("bp_accept_ready", int'(bus.in_ready), 1);
      @(negedge clk);
      bus.opcode = 4'd1; bus.A = 8'd9; bus.B = 8'd4;
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_valid", int'(bus.out_valid), 1);
         chk("bp_hold_result", int'(bus.ALU_Out), 3);
         chk("bp_hold_flags", int'({bus.flag_z, bus.flag_c, bus.flag_dz}), 0);
         chk("bp_in_ready_low", int'(bus.in_ready), 0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_ready", int'(bus.in_ready), 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("bp_b2b_valid", int'(bus.out_valid), 1);
      chk("bp_b2b_result", int'(bus.ALU_Out), 5);
      acc_m = 5;
      model_op(4, 0, 0, 1'b0, "bp_acc_kept");

      // acc_clr alone: no output, accumulator zeroed.
      @(negedge clk);
      bus.acc_clr = 1'b1;
      @(negedge clk);
      bus.acc_clr = 1'b0;
      chk("clr_alone_no_valid", int'(bus.out_valid), 0);
      acc_m = 0;
      model_op(4, 9, 0, 1'b0, "clr_alone_adda");

      // Reset in the middle of a divide.
      model_op(0, 1, 1, 1'b0, "rst_setup");
      @(negedge clk);
      bus.in_valid = 1'b1; bus.opcode = 4'd3; bus.A = 8'd200; bus.B = 8'd7;
      #1;
      chk("rst_div_accept", int'(bus.in_ready), 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_div_valid", int'(bus.out_valid), 0);
      chk("rst_mid_div_result", int'(bus.ALU_Out), 0);
      @(negedge clk);
      rst_n = 1'b1;
      acc_m = 0;
      model_op(4, 7, 0, 1'b0, "rst_after_adda");

      for (int i = 0; i < 200; i++) begin
         int op, a, b;
         bit clr;
         op  = $urandom_range(0, 15);
         a   = $urandom_range(0, MAXV);
         b   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MAXV);
         clr = ($urandom_range(0, 7) == 0);
         model_op(op, a, b, clr, $sformatf("rnd%0d_op%0d", i, op));
      end

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
